// File: rtl/lc3_pkg.sv
// lc3_pkg: shared types and constants for the LC-3 control sequencer.
//   state_t       - sequencer state encoding
//   OP_*          - IR[15:12] opcode values handled by the sequencer
//   PCMUX_*, ADDR2MUX_*, ALUK_* - datapath select encodings
//   is_mem_state  - true for states that hold an SRAM strobe low
package lc3_pkg;

    typedef enum logic [4:0] {
        HALTED  = 5'd0,
        FETCH1  = 5'd1,
        FETCH2  = 5'd2,
        FETCH3  = 5'd3,
        DECODE  = 5'd4,
        S_ADD   = 5'd5,
        S_AND   = 5'd6,
        S_NOT   = 5'd7,
        BR_TAKE = 5'd8,
        S_JMP   = 5'd9,
        JSR_1   = 5'd10,
        JSR_2   = 5'd11,
        LDR_1   = 5'd12,
        LDR_2   = 5'd13,
        LDR_3   = 5'd14,
        STR_1   = 5'd15,
        STR_2   = 5'd16,
        STR_3   = 5'd17,
        PAUSE_1 = 5'd18,
        PAUSE_W = 5'd19,
        PAUSE_2 = 5'd20
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_PC1   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2MUX_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2MUX_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2MUX_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2MUX_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    function automatic logic is_mem_state(input state_t s);
        return (s == FETCH2) || (s == LDR_2) || (s == STR_3);
    endfunction

endpackage

// File: rtl/lc3_ctrl_fsm_mem_wait_timer.sv
// mem_wait_timer: counts the cycles an SRAM strobe has been held low.
//   Clk    in  system clock
//   Reset  in  synchronous active-high reset, clears the count
//   start  in  restart the count at 0 on the next cycle
//   done   out high on the MEM_WAIT-th cycle of an access
module mem_wait_timer #(
    parameter int MEM_WAIT = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic start,
    output logic done
);

    localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_WAIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates at LAST so an idle timer never wraps back into a false done.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == LAST);

endmodule

// File: rtl/lc3_ctrl_fsm.sv
// lc3_ctrl_fsm: Moore control sequencer for the LC-3 datapath.
//   Clk, Reset                 clock and synchronous active-high reset
//   Run, Continue              start from HALTED / release from PAUSE
//   Opcode, IR_5, IR_11, BEN   instruction fields and branch enable
//   LD_*                       register load enables
//   Gate*                      bus drivers (one-hot or idle)
//   PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, MIO_EN   datapath selects
//   Mem_OE_N, Mem_WE_N         active-low SRAM strobes
//
// state   | meaning
// HALTED  | idle until Run
// FETCH1  | MAR<-PC, PC<-PC+1
// FETCH2  | SRAM read, LD_MDR on last wait cycle
// FETCH3  | IR<-MDR
// DECODE  | BEN load, dispatch on opcode
// S_ADD   | ADD writeback
// S_AND   | AND writeback
// S_NOT   | NOT writeback
// BR_TAKE | PC<-PC+off9
// S_JMP   | PC<-BaseR
// JSR_1   | R7<-PC
// JSR_2   | PC<-PC+off11 or BaseR
// LDR_1   | MAR<-BaseR+off6
// LDR_2   | SRAM read
// LDR_3   | DR<-MDR
// STR_1   | MAR<-BaseR+off6
// STR_2   | MDR<-SR
// STR_3   | SRAM write
// PAUSE_1 | LED load, one cycle
// PAUSE_W | wait for Continue high
// PAUSE_2 | wait for Continue low
module lc3_ctrl_fsm
    import lc3_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       MIO_EN,
    output logic       Mem_OE_N,
    output logic       Mem_WE_N
);

    state_t state_q, state_d;
    logic   ir_5_q, ir_11_q;
    logic   wait_start, wait_done;

    // Restart the wait count whenever a memory state is entered from elsewhere.
    assign wait_start = is_mem_state(state_d) && (state_d != state_q);

    mem_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .Clk   (Clk),
        .Reset (Reset),
        .start (wait_start),
        .done  (wait_done)
    );

    // IR bits that steer selects are latched at DECODE so outputs stay pure state decode.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= HALTED;
            ir_5_q  <= 1'b0;
            ir_11_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                ir_5_q  <= IR_5;
                ir_11_q <= IR_11;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HALTED:  if (Run) state_d = FETCH1;
            FETCH1:  state_d = FETCH2;
            FETCH2:  if (wait_done) state_d = FETCH3;
            FETCH3:  state_d = DECODE;
            DECODE: begin
                case (Opcode)
                    OP_ADD:   state_d = S_ADD;
                    OP_AND:   state_d = S_AND;
                    OP_NOT:   state_d = S_NOT;
                    OP_BR:    state_d = BEN ? BR_TAKE : FETCH1;
                    OP_JMP:   state_d = S_JMP;
                    OP_JSR:   state_d = JSR_1;
                    OP_LDR:   state_d = LDR_1;
                    OP_STR:   state_d = STR_1;
                    OP_PAUSE: state_d = PAUSE_1;
                    default:  state_d = FETCH1;
                endcase
            end
            JSR_1:   state_d = JSR_2;
            LDR_1:   state_d = LDR_2;
            LDR_2:   if (wait_done) state_d = LDR_3;
            STR_1:   state_d = STR_2;
            STR_2:   state_d = STR_3;
            STR_3:   if (wait_done) state_d = FETCH1;
            PAUSE_1, PAUSE_W: state_d = Continue ? PAUSE_2 : PAUSE_W;
            PAUSE_2: if (!Continue) state_d = FETCH1;
            default: state_d = FETCH1;
        endcase
    end

    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = PCMUX_PC1;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = ADDR2MUX_ZERO;
        ALUK       = ALUK_ADD;
        MIO_EN     = 1'b0;
        Mem_OE_N   = 1'b1;
        Mem_WE_N   = 1'b1;
        case (state_q)
            FETCH1: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
            end
            FETCH2, LDR_2: begin
                Mem_OE_N = 1'b0;
                MIO_EN   = 1'b1;
                LD_MDR   = wait_done;
            end
            FETCH3: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            DECODE:  LD_BEN = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                SR1MUX  = 1'b1;
                SR2MUX  = ir_5_q;
                ALUK    = (state_q == S_AND) ? ALUK_AND :
                          (state_q == S_NOT) ? ALUK_NOT : ALUK_ADD;
            end
            BR_TAKE: begin
                ADDR2MUX = ADDR2MUX_OFF9;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
            end
            S_JMP: begin
                SR1MUX   = 1'b1;
                ADDR1MUX = 1'b1;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
            end
            JSR_1: begin
                GatePC = 1'b1;
                DRMUX  = 1'b1;
                LD_REG = 1'b1;
            end
            JSR_2: begin
                if (ir_11_q) begin
                    ADDR2MUX = ADDR2MUX_OFF11;
                end else begin
                    ADDR1MUX = 1'b1;
                    SR1MUX   = 1'b1;
                end
                PCMUX = PCMUX_ADDER;
                LD_PC = 1'b1;
            end
            LDR_1, STR_1: begin
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = ADDR2MUX_OFF6;
            end
            LDR_3: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            STR_2: begin
                ALUK    = ALUK_PASSA;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
            end
            STR_3:   Mem_WE_N = 1'b0;
            PAUSE_1: LD_LED = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// tb_lc3_ctrl_fsm: directed bench for lc3_ctrl_fsm with MEM_WAIT=3.
// All outputs are packed into one vector and compared against hand-built
// per-state constants one cycle at a time.
module tb_lc3_ctrl_fsm;
    import lc3_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset, Run, Continue, IR_5, IR_11, BEN;
    logic [3:0] Opcode;
    logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE_N, Mem_WE_N;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    lc3_ctrl_fsm #(.MEM_WAIT(3)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .MIO_EN(MIO_EN),
        .Mem_OE_N(Mem_OE_N), .Mem_WE_N(Mem_WE_N)
    );

    logic [24:0] ctl;
    assign ctl = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                  GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX,
                  SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, MIO_EN, Mem_OE_N, Mem_WE_N};

    localparam logic [24:0] B_LDMAR  = 25'd1 << 24;
    localparam logic [24:0] B_LDMDR  = 25'd1 << 23;
    localparam logic [24:0] B_LDIR   = 25'd1 << 22;
    localparam logic [24:0] B_LDBEN  = 25'd1 << 21;
    localparam logic [24:0] B_LDCC   = 25'd1 << 20;
    localparam logic [24:0] B_LDREG  = 25'd1 << 19;
    localparam logic [24:0] B_LDPC   = 25'd1 << 18;
    localparam logic [24:0] B_LDLED  = 25'd1 << 17;
    localparam logic [24:0] B_GPC    = 25'd1 << 16;
    localparam logic [24:0] B_GMDR   = 25'd1 << 15;
    localparam logic [24:0] B_GALU   = 25'd1 << 14;
    localparam logic [24:0] B_GMAR   = 25'd1 << 13;
    localparam logic [24:0] B_PCADD  = 25'd2 << 11;
    localparam logic [24:0] B_DR7    = 25'd1 << 10;
    localparam logic [24:0] B_SR1    = 25'd1 << 9;
    localparam logic [24:0] B_SR2    = 25'd1 << 8;
    localparam logic [24:0] B_A1     = 25'd1 << 7;
    localparam logic [24:0] B_OFF6   = 25'd1 << 5;
    localparam logic [24:0] B_OFF9   = 25'd2 << 5;
    localparam logic [24:0] B_OFF11  = 25'd3 << 5;
    localparam logic [24:0] B_KAND   = 25'd1 << 3;
    localparam logic [24:0] B_KNOT   = 25'd2 << 3;
    localparam logic [24:0] B_KPASS  = 25'd3 << 3;
    localparam logic [24:0] B_MIO    = 25'd1 << 2;
    localparam logic [24:0] B_OEN    = 25'd1 << 1;
    localparam logic [24:0] B_WEN    = 25'd1;

    localparam logic [24:0] E_IDLE  = B_OEN | B_WEN;
    localparam logic [24:0] E_F1    = B_LDMAR | B_LDPC | B_GPC | E_IDLE;
    localparam logic [24:0] E_RD    = B_MIO | B_WEN;
    localparam logic [24:0] E_RDL   = E_RD | B_LDMDR;
    localparam logic [24:0] E_F3    = B_GMDR | B_LDIR | E_IDLE;
    localparam logic [24:0] E_DEC   = B_LDBEN | E_IDLE;
    localparam logic [24:0] E_ALU   = B_GALU | B_LDREG | B_LDCC | B_SR1 | E_IDLE;
    localparam logic [24:0] E_BRT   = B_OFF9 | B_PCADD | B_LDPC | E_IDLE;
    localparam logic [24:0] E_JMP   = B_SR1 | B_A1 | B_PCADD | B_LDPC | E_IDLE;
    localparam logic [24:0] E_JSR1  = B_GPC | B_DR7 | B_LDREG | E_IDLE;
    localparam logic [24:0] E_JSR2I = B_OFF11 | B_PCADD | B_LDPC | E_IDLE;
    localparam logic [24:0] E_MARO  = B_GMAR | B_LDMAR | B_SR1 | B_A1 | B_OFF6 | E_IDLE;
    localparam logic [24:0] E_LDR3  = B_GMDR | B_LDREG | B_LDCC | E_IDLE;
    localparam logic [24:0] E_STR2  = B_KPASS | B_GALU | B_LDMDR | E_IDLE;
    localparam logic [24:0] E_STR3  = B_OEN;
    localparam logic [24:0] E_P1    = B_LDLED | E_IDLE;

    task automatic check(input string tag, input logic [24:0] exp);
        checks++;
        assert (ctl === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, ctl, exp);
        end
    endtask

    task automatic check_halted(input string tag);
        checks++;
        assert (dut.state_q === HALTED)
        else begin
            errors++;
            $error("FAIL %s: observed state %0d expected HALTED", tag, dut.state_q);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic expect_next(input string tag, input logic [24:0] exp);
        @(posedge Clk);
        #1;
        check(tag, exp);
    endtask

    // FETCH2 x3 (LD_MDR on the third), FETCH3, DECODE.
    task automatic fetch(input string tag);
        expect_next({tag, "_f2a"}, E_RD);
        expect_next({tag, "_f2b"}, E_RD);
        expect_next({tag, "_f2c"}, E_RDL);
        expect_next({tag, "_f3"},  E_F3);
        expect_next({tag, "_dec"}, E_DEC);
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
        Opcode = 4'b0000; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;

        // Reset and idle in HALTED.
        @(posedge Clk); @(posedge Clk); #1;
        check("reset_outputs", E_IDLE);
        check_halted("reset_state");
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) expect_next("halted_idle", E_IDLE);
        check_halted("halted_after_idle");

        // ADD immediate.
        Opcode = OP_ADD; IR_5 = 1'b1; Run = 1'b1;
        expect_next("add_f1", E_F1);
        Run = 1'b0;
        fetch("add");
        expect_next("add_wb", E_ALU | B_SR2);
        expect_next("add_next_f1", E_F1);

        // AND register.
        Opcode = OP_AND; IR_5 = 1'b0;
        fetch("and");
        expect_next("and_wb", E_ALU | B_KAND);
        expect_next("and_next_f1", E_F1);

        // NOT.
        Opcode = OP_NOT;
        fetch("not");
        expect_next("not_wb", E_ALU | B_KNOT);
        expect_next("not_next_f1", E_F1);

        // LDR: two 3-cycle reads.
        Opcode = OP_LDR;
        fetch("ldr");
        expect_next("ldr_1", E_MARO);
        expect_next("ldr_2a", E_RD);
        expect_next("ldr_2b", E_RD);
        expect_next("ldr_2c", E_RDL);
        expect_next("ldr_3", E_LDR3);
        expect_next("ldr_next_f1", E_F1);

        // STR: write strobe for 3 cycles, OE never low.
        Opcode = OP_STR;
        fetch("str");
        expect_next("str_1", E_MARO);
        expect_next("str_2", E_STR2);
        expect_next("str_3a", E_STR3);
        expect_next("str_3b", E_STR3);
        expect_next("str_3c", E_STR3);
        expect_next("str_next_f1", E_F1);

        // BR not taken then taken.
        Opcode = OP_BR; BEN = 1'b0;
        fetch("brn");
        expect_next("brn_next_f1", E_F1);
        BEN = 1'b1;
        fetch("brt");
        expect_next("brt_take", E_BRT);
        expect_next("brt_next_f1", E_F1);

        // JMP.
        Opcode = OP_JMP;
        fetch("jmp");
        expect_next("jmp_exec", E_JMP);
        expect_next("jmp_next_f1", E_F1);

        // JSR (IR_11=1) then JSRR (IR_11=0).
        Opcode = OP_JSR; IR_11 = 1'b1;
        fetch("jsr");
        expect_next("jsr_1", E_JSR1);
        expect_next("jsr_2", E_JSR2I);
        expect_next("jsr_next_f1", E_F1);
        IR_11 = 1'b0;
        fetch("jsrr");
        expect_next("jsrr_1", E_JSR1);
        expect_next("jsrr_2", E_JMP);
        expect_next("jsrr_next_f1", E_F1);

        // Unlisted opcode is a NOP.
        Opcode = 4'b1111;
        fetch("nop");
        expect_next("nop_next_f1", E_F1);

        // PAUSE with Continue low first: LED for one cycle only.
        Opcode = OP_PAUSE;
        fetch("pz");
        expect_next("pz_led", E_P1);
        expect_next("pz_wait_a", E_IDLE);
        expect_next("pz_wait_b", E_IDLE);
        Continue = 1'b1;
        expect_next("pz_p2", E_IDLE);
        Continue = 1'b0;
        expect_next("pz_next_f1", E_F1);

        // PAUSE with Continue already high for 20 cycles.
        Continue = 1'b1;
        fetch("ph");
        expect_next("ph_led", E_P1);
        for (int i = 0; i < 20; i++) expect_next("ph_hold", E_IDLE);
        Continue = 1'b0;
        expect_next("ph_next_f1", E_F1);
        expect_next("ph_f2_after", E_RD);

        // Finish that fetch into a STR, then reset during STR_3.
        Opcode = OP_STR;
        expect_next("rst_f2b", E_RD);
        expect_next("rst_f2c", E_RDL);
        expect_next("rst_f3", E_F3);
        expect_next("rst_dec", E_DEC);
        expect_next("rst_str1", E_MARO);
        expect_next("rst_str2", E_STR2);
        expect_next("rst_str3", E_STR3);
        Reset = 1'b1;
        expect_next("rst_mid_str3", E_IDLE);
        check_halted("rst_mid_state");
        Reset = 1'b0;
        expect_next("rst_stays_halted", E_IDLE);
        check_halted("rst_stays_state");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
